// File: rtl/io_input_periph_if.sv
// LSU-side register bus of the input peripheral: one-cycle read/write strobes,
// registered read data with a matching valid.
interface io_input_periph_if;
    logic [3:0]  i_addr;
    logic        i_rd_en;
    logic        i_wr_en;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_rvalid;

    modport master (
        output i_addr, i_rd_en, i_wr_en, i_wdata,
        input  o_rdata, o_rvalid
    );

    modport slave (
        input  i_addr, i_rd_en, i_wr_en, i_wdata,
        output o_rdata, o_rvalid
    );
endinterface

// File: rtl/io_input_periph.sv
// Switch/button input peripheral: synchronises sw/btn, debounces buttons, latches press
// events (W1C). Optional mask register and interrupt output under `define IO_IRQ_EN.
module io_input_periph #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_io_sw,
    input  logic [31:0]        i_io_btn,
    io_input_periph_if.slave   bus,
    output logic               o_irq
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] SEL_SW    = 2'b00;
    localparam logic [1:0] SEL_BTN   = 2'b01;
    localparam logic [1:0] SEL_EVENT = 2'b10;
    localparam logic [1:0] SEL_MASK  = 2'b11;

    logic [31:0]      sw_p  [SYNC_STAGES];
    logic [31:0]      btn_p [SYNC_STAGES];
    logic [31:0]      sw_sync;
    logic [31:0]      btn_sync;
    logic [CNT_W-1:0] cnt_q [32];
    logic [31:0]      stable_q;
    logic [31:0]      evt_q;
    logic [31:0]      differ;
    logic [31:0]      done;
    logic [31:0]      rise;
    logic [31:0]      mask_rd;
    logic [31:0]      evt_clr;
    logic [31:0]      rd_mux;
    logic [31:0]      rdata_p1;
    logic             rd_vld_p1;
    logic [1:0]       sel;
    logic             unused_addr;

    assign sel         = bus.i_addr[3:2];
    assign unused_addr = ^bus.i_addr[1:0];

    // Synchroniser chains: the last stage is the only one the rest of the logic sees
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sw_p[s]  <= '0;
                btn_p[s] <= '0;
            end
        end else begin
            sw_p[0]  <= i_io_sw;
            btn_p[0] <= i_io_btn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sw_p[s]  <= sw_p[s-1];
                btn_p[s] <= btn_p[s-1];
            end
        end
    end

    assign sw_sync  = sw_p[SYNC_STAGES-1];
    assign btn_sync = btn_p[SYNC_STAGES-1];

    // A bit commits on the edge its counter reaches the last step while still differing
    assign differ = btn_sync ^ stable_q;

    always_comb begin
        done = '0;
        for (int i = 0; i < 32; i++)
            done[i] = differ[i] && (cnt_q[i] == CNT_LAST);
    end

    assign rise = done & btn_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < 32; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (!differ[i]) begin
                    cnt_q[i] <= '0;
                end else if (done[i]) begin
                    stable_q[i] <= btn_sync[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Set is OR-ed in after the clear so a same-cycle press survives the W1C
    assign evt_clr = (bus.i_wr_en && sel == SEL_EVENT) ? bus.i_wdata : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            evt_q <= '0;
        else
            evt_q <= (evt_q & ~evt_clr) | rise;
    end

`ifdef IO_IRQ_EN
    logic [31:0] mask_q;
    logic        irq_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_q <= '0;
            irq_p1 <= 1'b0;
        end else begin
            if (bus.i_wr_en && sel == SEL_MASK)
                mask_q <= bus.i_wdata;
            irq_p1 <= |(evt_q & mask_q);
        end
    end

    assign mask_rd = mask_q;
    assign o_irq   = irq_p1;
`else
    assign mask_rd = '0;
    assign o_irq   = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_SW:    rd_mux = sw_sync;
            SEL_BTN:   rd_mux = stable_q;
            SEL_EVENT: rd_mux = evt_q;
            SEL_MASK:  rd_mux = mask_rd;
            default:   rd_mux = '0;
        endcase
    end

    // Read stage: data samples pre-write state, held until the next read
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_p1  <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= bus.i_rd_en;
            if (bus.i_rd_en)
                rdata_p1 <= rd_mux;
        end
    end

    assign bus.o_rdata  = rdata_p1;
    assign bus.o_rvalid = rd_vld_p1;

endmodule

// File: tb/tb_io_input_periph.sv
// Directed bench for io_input_periph: table of register accesses plus cycle-exact
// sequences for sync latency, debounce, W1C, irq and mid-operation reset.
module tb_io_input_periph;

`ifdef IO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] sw = '0;
    logic [31:0] btn = '0;
    logic        irq;
    int          checks = 0;
    int          failures = 0;

    io_input_periph_if bus ();

    io_input_periph #(.DEBOUNCE_CYC(4), .SYNC_STAGES(2)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_io_sw  (sw),
        .i_io_btn (btn),
        .bus      (bus),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sw;
        logic [31:0] btn;
        int          settle;
        logic        wr;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All bus tasks are entered at a negedge and return at a negedge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.i_addr  = a;
        bus.i_wdata = d;
        bus.i_wr_en = 1'b1;
        @(negedge clk);
        bus.i_wr_en = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [3:0] a, input logic [31:0] exp);
        bus.i_addr  = a;
        bus.i_rd_en = 1'b1;
        @(negedge clk);
        bus.i_rd_en = 1'b0;
        check({name, "_rvalid"}, {31'd0, bus.o_rvalid}, 32'd1);
        check(name, bus.o_rdata, exp);
    endtask

    // Back-to-back reads; only the n-th capture may show exp, earlier ones read 0
    task automatic watch(input string name, input logic [3:0] a, input logic [31:0] exp, input int n);
        bus.i_addr  = a;
        bus.i_rd_en = 1'b1;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            check($sformatf("%s_cap%0d", name, j), bus.o_rdata, (j == n) ? exp : 32'd0);
        end
        bus.i_rd_en = 1'b0;
    endtask

    task automatic do_reset(input string name);
        #2 rst_n = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_addr  = '0;
        bus.i_wdata = '0;
        #1;
        check({name, "_rdata"}, bus.o_rdata, 32'd0);
        check({name, "_rvalid"}, {31'd0, bus.o_rvalid}, 32'd0);
        check({name, "_irq"}, {31'd0, irq}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'hA5A5_A5A5, 32'h0,  4, 1'b0, 4'h0, 32'h0,         4'h0, 32'hA5A5_A5A5};
        vecs[1]  = '{32'h1234_5678, 32'h0,  4, 1'b0, 4'h0, 32'h0,         4'h0, 32'h1234_5678};
        vecs[2]  = '{32'h1234_5678, 32'hF0, 10, 1'b0, 4'h0, 32'h0,        4'h4, 32'h0000_00F0};
        vecs[3]  = '{32'h1234_5678, 32'hF0, 0, 1'b0, 4'h0, 32'h0,         4'h8, 32'h0000_00F0};
        vecs[4]  = '{32'h1234_5678, 32'h0, 10, 1'b0, 4'h0, 32'h0,         4'h4, 32'h0};
        vecs[5]  = '{32'h1234_5678, 32'h0,  0, 1'b0, 4'h0, 32'h0,         4'h8, 32'h0000_00F0};
        vecs[6]  = '{32'h1234_5678, 32'h0,  0, 1'b1, 4'h8, 32'h30,        4'h8, 32'h0000_00C0};
        vecs[7]  = '{32'h1234_5678, 32'h0,  0, 1'b1, 4'h4, 32'hFFFF_FFFF, 4'h4, 32'h0};
        vecs[8]  = '{32'h1234_5678, 32'h0,  0, 1'b1, 4'h0, 32'h0,         4'h0, 32'h1234_5678};
        vecs[9]  = '{32'h1234_5678, 32'h0,  0, 1'b1, 4'hC, 32'hFFFF_FFFF, 4'hD, IRQ ? 32'hFFFF_FFFF : 32'h0};
        vecs[10] = '{32'h1234_5678, 32'h0,  0, 1'b1, 4'h8, 32'hFFFF_FFFF, 4'h9, 32'h0};
        vecs[11] = '{32'hDEAD_BEEF, 32'h0,  4, 1'b0, 4'h0, 32'h0,         4'h3, 32'hDEAD_BEEF};

        bus.i_addr  = '0;
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_wdata = '0;
        @(negedge clk);
        do_reset("rst0");

        for (int v = 0; v < 12; v++) begin
            sw  = vecs[v].sw;
            btn = vecs[v].btn;
            repeat (vecs[v].settle) @(negedge clk);
            if (vecs[v].wr) bus_write(vecs[v].waddr, vecs[v].wdata);
            bus_read($sformatf("vec%0d", v), vecs[v].raddr, vecs[v].exp);
        end

        // Switch sync latency: captures at edge 2 and 3 after the input change
        do_reset("rst1");
        sw = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.i_addr  = 4'h0;
        bus.i_rd_en = 1'b1;
        @(negedge clk);
        check("sw_early", bus.o_rdata, 32'h0);
        @(negedge clk);
        check("sw_synced", bus.o_rdata, 32'hA5A5_A5A5);
        bus.i_rd_en = 1'b0;
        @(negedge clk);
        check("rvalid_drop", {31'd0, bus.o_rvalid}, 32'd0);
        check("rdata_hold", bus.o_rdata, 32'hA5A5_A5A5);

        // Glitch one cycle shorter than the debounce window is rejected
        btn = 32'h1;
        repeat (3) @(negedge clk);
        btn = 32'h0;
        repeat (12) @(negedge clk);
        bus_read("glitch_btn", 4'h4, 32'h0);
        bus_read("glitch_evt", 4'h8, 32'h0);

        // Pulse exactly one window long is accepted, event stays sticky after release
        btn = 32'h1;
        repeat (4) @(negedge clk);
        btn = 32'h0;
        repeat (12) @(negedge clk);
        bus_read("pulse4_btn", 4'h4, 32'h0);
        bus_read("pulse4_evt", 4'h8, 32'h1);
        bus_write(4'h8, 32'h1);
        bus_read("pulse4_clr", 4'h8, 32'h0);

        btn = 32'hB5B5_B5B5;
        watch("btn_deb", 4'h4, 32'hB5B5_B5B5, 7);
        bus_read("btn_evt", 4'h8, 32'hB5B5_B5B5);

        bus_write(4'h8, 32'h0000_00FF);
        bus_read("w1c_part", 4'h8, 32'hB5B5_B500);
        bus_write(4'h0, 32'hFFFF_FFFF);
        bus_read("sw_ro", 4'h0, 32'hA5A5_A5A5);

        // Read and W1C in the same cycle: read sees the pre-write value
        bus.i_addr  = 4'h8;
        bus.i_wdata = 32'hFFFF_FFFF;
        bus.i_rd_en = 1'b1;
        bus.i_wr_en = 1'b1;
        @(negedge clk);
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        check("rdwr_pre", bus.o_rdata, 32'hB5B5_B500);
        bus_read("rdwr_post", 4'h8, 32'h0);

        // W1C lands on the same edge bit1 commits its press: set wins
        btn = 32'hB5B5_B5B7;
        repeat (5) @(negedge clk);
        bus_write(4'h8, 32'h2);
        bus_read("setwins_evt", 4'h8, 32'h2);
        bus_read("setwins_btn", 4'h4, 32'hB5B5_B5B7);

        // Interrupt path (tied low without the mask register)
        btn = 32'h0;
        do_reset("rst2");
        bus_write(4'hC, 32'h1);
        bus_read("mask_rd", 4'hC, IRQ ? 32'h1 : 32'h0);
        btn = 32'h1;
        repeat (6) @(negedge clk);
        check("irq_before", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, {31'd0, IRQ});
        bus.i_addr  = 4'h8;
        bus.i_wdata = 32'h1;
        bus.i_wr_en = 1'b1;
        @(negedge clk);
        bus.i_wr_en = 1'b0;
        check("irq_hold", {31'd0, irq}, {31'd0, IRQ});
        @(negedge clk);
        check("irq_fall", {31'd0, irq}, 32'd0);
        bus_read("irq_evt_clr", 4'h8, 32'h0);

        // Reset mid-count discards progress; a held button re-debounces and re-fires
        btn = 32'h0;
        do_reset("rst3");
        sw = 32'hA5A5_A5A5;
        repeat (4) @(negedge clk);
        bus_read("pre_rst_sw", 4'h0, 32'hA5A5_A5A5);
        btn = 32'hB5B5_B5B5;
        repeat (4) @(negedge clk);
        do_reset("rst_mid");
        watch("refire_evt", 4'h8, 32'hB5B5_B5B5, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
